// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: RAW hazard detection, SRAM wait-state FSM, branch flush,
// and a saturating count of front-end stall cycles.
module pipeline_hazard_controller #(
    parameter int unsigned MEM_LATENCY = 5,
    parameter int unsigned CNT_W       = 3,
    parameter int unsigned PERF_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              forward_en,
    input  logic [3:0]        id_src1,
    input  logic [3:0]        id_src2,
    input  logic              id_two_src,
    input  logic              id_ignore_hazard,
    input  logic [3:0]        exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_read,
    input  logic [3:0]        mem_dest,
    input  logic              mem_wb_en,
    input  logic              exe_branch_taken,
    input  logic              mem_read_req,
    input  logic              mem_write_req,
    output logic              hazard,
    output logic              freeze_front,
    output logic              freeze_back,
    output logic              flush,
    output logic              sram_done,
    output logic [1:0]        mem_state,
    output logic [PERF_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(MEM_LATENCY - 2);
    localparam logic [PERF_W-1:0] PERF_MAX  = '1;

    mem_state_t       state;
    mem_state_t       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             req;
    logic             mem_stall;
    logic             raw;
    logic             exe_m1;
    logic             exe_m2;
    logic             mem_m1;
    logic             mem_m2;

    // RAW detection against EXE (and MEM when nothing forwards)
    always_comb begin
        exe_m1 = exe_wb_en && (exe_dest == id_src1);
        exe_m2 = exe_wb_en && (exe_dest == id_src2) && id_two_src;
        mem_m1 = mem_wb_en && (mem_dest == id_src1);
        mem_m2 = mem_wb_en && (mem_dest == id_src2) && id_two_src;
        if (id_ignore_hazard) begin
            raw = 1'b0;
        end else if (forward_en) begin
            raw = exe_mem_read && (exe_m1 || exe_m2);
        end else begin
            raw = exe_m1 || exe_m2 || mem_m1 || mem_m2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            stall_count <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (freeze_front && (stall_count != PERF_MAX)) begin
                stall_count <= stall_count + PERF_W'(1);
            end
        end
    end

    // DONE is the retiring cycle of the access, so req is not sampled there
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        req          = mem_read_req || mem_write_req;
        mem_stall    = 1'b0;
        sram_done    = 1'b0;
        case (state)
            IDLE: begin
                mem_stall = req;
                if (req) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = WAIT_INIT;
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (wait_cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    wait_cnt_nxt = wait_cnt - CNT_W'(1);
                end
            end
            DONE: begin
                sram_done = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Priority: memory stall, then branch, then data hazard
    assign freeze_back  = mem_stall;
    assign flush        = exe_branch_taken && !mem_stall;
    assign freeze_front = mem_stall || (raw && !exe_branch_taken);
    assign hazard       = raw && !mem_stall && !exe_branch_taken;
    assign mem_state    = state;

endmodule
